mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the load-store buffer; it also serves the instruction fetcher.
- Arbitrates between one LSB load/store request and one 32-bit instruction-fetch request.
- Drives the 8-bit RAM/IO port one byte per cycle, assembles and sign/zero-extends load data, and returns single-cycle completion pulses.
- LSB requests take priority; fetch is served only when no LSB request is pending.

Parameters:
IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region (0x30000, 0x30004)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low freezes all state
rob_clear  in  1  misprediction flush
is_io  in  1  LSB request valid, level, held until mem_res_avail
is_store  in  1  0 load, 1 store
io_addr  in  32  byte address
io_data  in  32  store data
io_op  in  3  funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
mem_res_avail  out  1  LSB completion pulse
mem_res  out  32  extended load data (0 for stores)
mem_stuck  out  1  high while serving a fetch
if_req  in  1  fetch request, level, held until if_done
if_addr  in  32  fetch address
if_done  out  1  fetch completion pulse
if_data  out  32  fetched word, little-endian
mem_din  in  8  RAM read byte, valid the cycle after its address
mem_dout  out  8  write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 write, 0 read
io_buffer_full  in  1  IO write must not be issued while high

Behaviour:
- Interface decisions (already decided): one clock, clk_in; reset rst_in is synchronous and active-high.
- Reset (rst_in=1 at a clock edge): the following are all 0 and state returns to IDLE:
  - mem_res_avail, mem_res, if_done, if_data, mem_stuck
  - mem_a, mem_dout, mem_wr
- rdy_in=0: no state change; mem_wr forced 0.
- Request size: len = 1 << io_op[1:0] (1, 2 or 4 bytes). Fetch len is always 4.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - is_io && !is_store -> READ.
  - is_io && is_store -> WRITE.
  - else if_req -> READ (fetch).
  - The request's addr, data, op and source are latched; the byte counter k is cleared to 0.
- READ:
  - Cycle k drives mem_a = addr+k, mem_wr=0 for k < len.
  - At cycle k >= 1 the controller captures mem_din into byte k-1.
  - Total len+1 cycles, then DONE.
- WRITE:
  - Each cycle drives mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr=1.
  - If addr[17:16]==IO_HI and io_buffer_full=1, the controller holds with mem_wr=0 and k unchanged.
  - After byte len-1 -> DONE.
- DONE, exactly one cycle:
  - LSB source: mem_res_avail=1, with mem_res = sign-extended (op[2]=0) or zero-extended (op[2]=1) value for loads, 0 for stores.
  - Fetch source: if_done=1, if_data = 4 assembled bytes.
  - Then IDLE.
  - The pulse ensures a held is_io/if_req is not re-accepted, because the requester drops it on the pulse cycle.
- Outside READ/WRITE: mem_wr=0, mem_a=0.
- mem_stuck = 1 iff the current transaction's source is fetch and state != IDLE.
- rob_clear:
  - A READ (load or fetch) aborts and returns to IDLE with no completion pulse.
  - A WRITE finishes its remaining bytes, then suppresses the DONE pulse.
  - A clear in IDLE has no effect; a request accepted that same cycle is discarded.
- Address arithmetic wraps modulo 2^32; no alignment checks are made (unaligned accesses are byte-serial and legal).
- Simultaneous is_io and if_req in IDLE: the LSB request wins, and the fetch waits until the LSB transaction completes.

Decomposition:
- const.v gets:
  - state encodings S_IDLE/S_READ/S_WRITE/S_DONE
  - funct3 width macros
  - IO region constant
- One natural sub-module, mem_ld_ext: a combinational byte assembler with sign/zero extension taking 4 bytes plus op; it is kept separate for unit testing.

Test Plan:
- Reset mid-WRITE of sw at 0x100 after 2 bytes -> next cycle mem_wr=0, mem_a=0, all pulses 0, state IDLE.
- lw at 0x200, RAM holds 0x78,0x56,0x34,0x12 -> mem_a 0x200..0x203 on 4 consecutive cycles, mem_res_avail pulse on cycle 6 after acceptance with mem_res=0x12345678.
- lb then lbu at 0x10 holding 0xF0 -> mem_res 0xFFFFFFF0 then 0x000000F0; lh at 0x20 holding 0x01,0x80 -> 0xFFFF8001.
- sb to 0x30000 data 0x41 with io_buffer_full high 3 cycles -> mem_wr stays 0 for those 3 cycles, then 1 with mem_dout=0x41; completion pulse follows with mem_res=0.
- is_io load and if_req asserted the same cycle -> LSB load served first and mem_stuck=0 throughout; fetch then runs with mem_stuck=1 and if_done pulses with the correct word.
- rob_clear during a lw at byte 2 -> no mem_res_avail; rob_clear during sw at byte 1 -> bytes 2 and 3 still written, no pulse.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] F3_LW = 3'b010;

  localparam logic [1:0] IO_REGION = 2'b11;

  function automatic logic [2:0] req_len(input logic [2:0] op);
    case (op[1:0])
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// Combinational load-data extender: little-endian word in, sign/zero-extended result out.
module mem_ld_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  op,
  output logic [31:0] res
);

  always_comb begin
    res = raw;
    case (op[1:0])
      SZ_B:    res = op[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    res = op[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller arbitrating LSB load/store against instruction fetch.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_REGION
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        is_io,
  input  logic        is_store,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_data,
  input  logic [2:0]  io_op,
  output logic        mem_res_avail,
  output logic [31:0] mem_res,
  output logic        mem_stuck,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  op;
  logic        from_fetch;
  logic [2:0]  k;
  logic        cleared;
  logic [31:0] word_q;
  logic [31:0] word_nxt;
  logic [31:0] ext_res;
  logic [2:0]  len;
  logic [1:0]  cap_idx;
  logic        mem_wr_q;
  logic        io_blocked;

  assign len        = req_len(op);
  assign cap_idx    = k[1:0] - 2'd1;
  assign io_blocked = (addr[17:16] == IO_HI) && io_buffer_full;
  assign mem_wr     = mem_wr_q & rdy_in;

  // In READ, k counts the address cycle; the byte for address k-1 arrives now.
  always_comb begin
    word_nxt = word_q;
    if (state == S_READ && k != 3'd0)
      word_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  mem_ld_ext u_ld_ext (
    .raw (word_nxt),
    .op  (op),
    .res (ext_res)
  );

  // Outputs are registered for the cycle that follows each edge; in WRITE,
  // k counts bytes already issued, so k==len means the last byte is on the bus.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      addr          <= '0;
      data          <= '0;
      op            <= '0;
      from_fetch    <= 1'b0;
      k             <= '0;
      cleared       <= 1'b0;
      word_q        <= '0;
      mem_res_avail <= 1'b0;
      mem_res       <= '0;
      if_done       <= 1'b0;
      if_data       <= '0;
      mem_stuck     <= 1'b0;
      mem_a         <= '0;
      mem_dout      <= '0;
      mem_wr_q      <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        S_IDLE: begin
          mem_res_avail <= 1'b0;
          if_done       <= 1'b0;
          mem_a         <= '0;
          mem_wr_q      <= 1'b0;
          cleared       <= 1'b0;
          word_q        <= '0;
          k             <= '0;
          if (!rob_clear && is_io) begin
            addr       <= io_addr;
            data       <= io_data;
            op         <= io_op;
            from_fetch <= 1'b0;
            mem_a      <= io_addr;
            if (is_store) begin
              state <= S_WRITE;
              if (!((io_addr[17:16] == IO_HI) && io_buffer_full)) begin
                mem_dout <= io_data[7:0];
                mem_wr_q <= 1'b1;
                k        <= 3'd1;
              end
            end else begin
              state <= S_READ;
            end
          end else if (!rob_clear && if_req) begin
            addr       <= if_addr;
            data       <= '0;
            op         <= F3_LW;
            from_fetch <= 1'b1;
            mem_stuck  <= 1'b1;
            mem_a      <= if_addr;
            state      <= S_READ;
          end
        end

        S_READ: begin
          word_q <= word_nxt;
          if (rob_clear) begin
            state     <= S_IDLE;
            mem_a     <= '0;
            mem_stuck <= 1'b0;
          end else if (k == len) begin
            state <= S_DONE;
            mem_a <= '0;
            if (from_fetch) begin
              if_done <= 1'b1;
              if_data <= word_nxt;
            end else begin
              mem_res_avail <= 1'b1;
              mem_res       <= ext_res;
            end
          end else begin
            k     <= k + 3'd1;
            mem_a <= (k + 3'd1 < len) ? addr + {29'b0, k + 3'd1} : '0;
          end
        end

        S_WRITE: begin
          if (rob_clear) cleared <= 1'b1;
          if (k == len) begin
            mem_wr_q <= 1'b0;
            mem_a    <= '0;
            if (cleared || rob_clear) begin
              state <= S_IDLE;
            end else begin
              state         <= S_DONE;
              mem_res_avail <= 1'b1;
              mem_res       <= '0;
            end
          end else if (io_blocked) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_wr_q <= 1'b1;
            mem_a    <= addr + {29'b0, k};
            mem_dout <= data[{k[1:0], 3'b000} +: 8];
            k        <= k + 3'd1;
          end
        end

        S_DONE: begin
          state         <= S_IDLE;
          mem_res_avail <= 1'b0;
          if_done       <= 1'b0;
          mem_stuck     <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a byte-addressed RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, is_io, is_store, if_req, io_buffer_full;
  logic [31:0] io_addr, io_data, if_addr;
  logic [2:0]  io_op;
  logic        mem_res_avail, mem_stuck, if_done, mem_wr;
  logic [31:0] mem_res, if_data, mem_a;
  logic [7:0]  mem_din, mem_dout;

  int total = 0;
  int bad   = 0;
  int n_avail = 0;
  int n_ifdone = 0;

  logic [7:0]  ram [logic [31:0]];
  logic        full_at_edge = 1'b0;
  logic [39:0] wr_q [$];
  bit          rand_full = 1'b0;
  logic [31:0] a_trace [8];
  logic [2:0]  ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .rob_clear      (rob_clear),
    .is_io          (is_io),
    .is_store       (is_store),
    .io_addr        (io_addr),
    .io_data        (io_data),
    .io_op          (io_op),
    .mem_res_avail  (mem_res_avail),
    .mem_res        (mem_res),
    .mem_stuck      (mem_stuck),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Expected load value: little-endian bytes, then sign fix-up by arithmetic.
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] op);
    int unsigned n;
    longint unsigned v;
    n = 1 << op[1:0];
    v = 0;
    for (int unsigned i = 0; i < n; i++)
      v += longint'(ram_rd(a + i)) << (8 * i);
    if (!op[2] && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM: read data valid the cycle after the address; writes commit at the edge.
  always @(posedge clk_in) begin
    full_at_edge <= io_buffer_full;
    mem_din <= ram_rd(mem_a);
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
  end

  always @(negedge clk_in) begin
    if (mem_res_avail === 1'b1) n_avail++;
    if (if_done === 1'b1) n_ifdone++;
    if (mem_wr === 1'b1) begin
      wr_q.push_back({mem_a, mem_dout});
      if (mem_a[17:16] == 2'b11) check("io_wr_while_full", 64'(full_at_edge), 64'd0);
    end
    if (rand_full) io_buffer_full = 1'($urandom_range(0, 1));
  end

  task automatic lsb_req(input bit st, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] op, output logic [31:0] res, output int cyc);
    bit seen;
    @(negedge clk_in);
    is_io = 1'b1; is_store = st; io_addr = a; io_data = d; io_op = op;
    cyc = 0; seen = 1'b0; res = '0;
    while (!seen && cyc < 60) begin
      @(negedge clk_in);
      if (cyc < 8) a_trace[cyc] = mem_a;
      cyc++;
      if (mem_res_avail) begin
        res = mem_res; seen = 1'b1; is_io = 1'b0;
      end
    end
    is_io = 1'b0;
    check("lsb_pulse_seen", 64'(seen), 64'd1);
  endtask

  task automatic fetch_req(input logic [31:0] a, output logic [31:0] w, output int cyc);
    bit seen;
    @(negedge clk_in);
    if_req = 1'b1; if_addr = a;
    cyc = 0; seen = 1'b0; w = '0;
    while (!seen && cyc < 60) begin
      @(negedge clk_in);
      cyc++;
      if (if_done) begin
        w = if_data; seen = 1'b1; if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    check("if_pulse_seen", 64'(seen), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr"},    64'(mem_wr), 64'd0);
    check({tag, "_a"},     64'(mem_a), 64'd0);
    check({tag, "_dout"},  64'(mem_dout), 64'd0);
    check({tag, "_avail"}, 64'(mem_res_avail), 64'd0);
    check({tag, "_res"},   64'(mem_res), 64'd0);
    check({tag, "_ifd"},   64'(if_done), 64'd0);
    check({tag, "_ifdat"}, 64'(if_data), 64'd0);
    check({tag, "_stuck"}, 64'(mem_stuck), 64'd0);
  endtask

  initial begin
    logic [31:0] res, a, d, e;
    int cyc, n0, kind, sel, len, stuck_lsb, stuck_f, guard;
    logic [2:0] op;
    bit lsb_seen, if_seen, hit;

    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; is_io = 1'b0; is_store = 1'b0;
    if_req = 1'b0; io_addr = '0; io_data = '0; io_op = '0; if_addr = '0; io_buffer_full = 1'b0;
    ram[32'h200] = 8'h78; ram[32'h201] = 8'h56; ram[32'h202] = 8'h34; ram[32'h203] = 8'h12;
    ram[32'h10] = 8'hF0; ram[32'h20] = 8'h01; ram[32'h21] = 8'h80;
    repeat (3) @(negedge clk_in);
    check_idle_outputs("reset");
    rst_in = 1'b0;

    // lw timing and addresses
    lsb_req(1'b0, 32'h200, 32'h0, 3'b010, res, cyc);
    check("lw_res", 64'(res), 64'h12345678);
    check("lw_cycles", 64'(cyc), 64'd6);
    for (int i = 0; i < 4; i++) check("lw_addr", 64'(a_trace[i]), 64'(32'h200 + i));

    lsb_req(1'b0, 32'h10, 32'h0, 3'b000, res, cyc);
    check("lb_res", 64'(res), 64'hFFFFFFF0);
    lsb_req(1'b0, 32'h10, 32'h0, 3'b100, res, cyc);
    check("lbu_res", 64'(res), 64'h000000F0);
    lsb_req(1'b0, 32'h20, 32'h0, 3'b001, res, cyc);
    check("lh_res", 64'(res), 64'hFFFF8001);

    // IO store held off by a full buffer
    @(negedge clk_in);
    is_io = 1'b1; is_store = 1'b1; io_addr = 32'h30000; io_data = 32'h41; io_op = 3'b000;
    io_buffer_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      check("io_hold_wr", 64'(mem_wr), 64'd0);
    end
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    check("io_wr", 64'(mem_wr), 64'd1);
    check("io_dout", 64'(mem_dout), 64'h41);
    check("io_a", 64'(mem_a), 64'h30000);
    @(negedge clk_in);
    check("io_avail", 64'(mem_res_avail), 64'd1);
    check("io_res", 64'(mem_res), 64'd0);
    is_io = 1'b0;

    // Simultaneous LSB load and fetch: LSB first
    @(negedge clk_in);
    is_io = 1'b1; is_store = 1'b0; io_addr = 32'h200; io_op = 3'b010;
    if_req = 1'b1; if_addr = 32'h80;
    e = exp_load(32'h80, 3'b010);
    lsb_seen = 1'b0; if_seen = 1'b0; stuck_lsb = 0; stuck_f = 0; guard = 0;
    while (!if_seen && guard < 60) begin
      @(negedge clk_in);
      guard++;
      if (!lsb_seen) begin
        if (mem_stuck) stuck_lsb++;
        if (mem_res_avail) begin
          lsb_seen = 1'b1; is_io = 1'b0;
          check("arb_lsb_res", 64'(mem_res), 64'h12345678);
        end
      end else begin
        if (mem_stuck) stuck_f++;
        if (if_done) begin
          if_seen = 1'b1; if_req = 1'b0;
          check("arb_if_data", 64'(if_data), 64'(e));
        end
      end
    end
    is_io = 1'b0; if_req = 1'b0;
    check("arb_both_done", 64'({lsb_seen, if_seen}), 64'b11);
    check("arb_stuck_lsb", 64'(stuck_lsb), 64'd0);
    check("arb_stuck_fetch", 64'(stuck_f), 64'd6);

    // rob_clear during lw at byte 2
    n0 = n_avail;
    @(negedge clk_in);
    is_io = 1'b1; is_store = 1'b0; io_addr = 32'h200; io_op = 3'b010;
    hit = 1'b0; guard = 0;
    while (!hit && guard < 20) begin
      @(negedge clk_in);
      guard++;
      if (mem_a == 32'h202) begin hit = 1'b1; rob_clear = 1'b1; is_io = 1'b0; end
    end
    @(negedge clk_in);
    rob_clear = 1'b0;
    check("lw_clr_a", 64'(mem_a), 64'd0);
    repeat (10) @(negedge clk_in);
    check("lw_clr_nopulse", 64'(n_avail - n0), 64'd0);

    // rob_clear during sw at byte 1: remaining bytes still written
    n0 = n_avail;
    wr_q.delete();
    @(negedge clk_in);
    is_io = 1'b1; is_store = 1'b1; io_addr = 32'h300; io_data = 32'hA1B2C3D4; io_op = 3'b010;
    hit = 1'b0; guard = 0;
    while (!hit && guard < 20) begin
      @(negedge clk_in);
      guard++;
      if (mem_wr && mem_a == 32'h301) begin hit = 1'b1; rob_clear = 1'b1; is_io = 1'b0; end
    end
    @(negedge clk_in);
    rob_clear = 1'b0;
    repeat (10) @(negedge clk_in);
    check("sw_clr_nopulse", 64'(n_avail - n0), 64'd0);
    check("sw_clr_count", 64'(wr_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++)
      check("sw_clr_byte", 64'(wr_q[i]), 64'({32'h300 + 32'(i), 8'(32'hA1B2C3D4 >> (8 * i))}));

    // Reset in the middle of a sw
    @(negedge clk_in);
    is_io = 1'b1; is_store = 1'b1; io_addr = 32'h100; io_data = 32'h11223344; io_op = 3'b010;
    hit = 1'b0; guard = 0;
    while (!hit && guard < 20) begin
      @(negedge clk_in);
      guard++;
      if (mem_wr && mem_a == 32'h101) begin hit = 1'b1; rst_in = 1'b1; is_io = 1'b0; end
    end
    @(negedge clk_in);
    check_idle_outputs("midrst");
    rst_in = 1'b0;

    // Global enable low freezes the write on the bus
    wr_q.delete();
    @(negedge clk_in);
    is_io = 1'b1; is_store = 1'b1; io_addr = 32'h500; io_data = 32'h5A; io_op = 3'b000;
    @(posedge clk_in);
    #1 rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      check("frozen_wr", 64'(mem_wr), 64'd0);
      check("frozen_a", 64'(mem_a), 64'h500);
    end
    @(posedge clk_in);
    #1 rdy_in = 1'b1;
    guard = 0; hit = 1'b0;
    while (!hit && guard < 20) begin
      @(negedge clk_in);
      guard++;
      if (mem_res_avail) begin hit = 1'b1; is_io = 1'b0; end
    end
    is_io = 1'b0;
    check("frozen_done", 64'(hit), 64'd1);
    check("frozen_count", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() > 0) check("frozen_byte", 64'(wr_q[0]), 64'({32'h500, 8'h5A}));

    // Randomized mix of loads, stores and fetches
    rand_full = 1'b1;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      sel  = $urandom_range(0, 3);
      case (sel)
        0, 1:    a = 32'h1000 + 32'($urandom_range(0, 31));
        2:       a = 32'h30000 + 32'($urandom_range(0, 7));
        default: a = 32'hFFFFFFFD + 32'($urandom_range(0, 2));
      endcase
      d = $urandom;
      if (kind == 0) begin
        op = ops[$urandom_range(0, 4)];
        len = 1 << op[1:0];
        e = exp_load(a, op);
        lsb_req(1'b0, a, d, op, res, cyc);
        check("rnd_load", 64'(res), 64'(e));
        check("rnd_load_cyc", 64'(cyc), 64'(len + 2));
      end else if (kind == 1) begin
        op = ops[$urandom_range(0, 2)];
        len = 1 << op[1:0];
        wr_q.delete();
        lsb_req(1'b1, a, d, op, res, cyc);
        check("rnd_store_res", 64'(res), 64'd0);
        check("rnd_store_cnt", 64'(wr_q.size()), 64'(len));
        for (int i = 0; i < len && i < wr_q.size(); i++)
          check("rnd_store_byte", 64'(wr_q[i]), 64'({a + 32'(i), 8'(d >> (8 * i))}));
      end else begin
        e = exp_load(a, 3'b010);
        fetch_req(a, res, cyc);
        check("rnd_fetch", 64'(res), 64'(e));
        check("rnd_fetch_cyc", 64'(cyc), 64'd6);
      end
    end
    rand_full = 1'b0;
    io_buffer_full = 1'b0;

    repeat (2) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
